// File: rtl/cnn_pkg.sv
// Shared constants, kernel/weight tables and FSM state type for the CNN core.
package cnn_pkg;

    localparam int unsigned IMG_DIM    = 8;
    localparam int unsigned CONV_DIM   = 6;
    localparam int unsigned POOL_DIM   = 3;
    localparam int unsigned IMG_PIXELS = IMG_DIM * IMG_DIM;
    localparam int unsigned CONV_SIZE  = CONV_DIM * CONV_DIM;
    localparam int unsigned POOL_SIZE  = POOL_DIM * POOL_DIM;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned WIN_SIZE   = 9;

    typedef logic signed [WORD_W-1:0] word_t;

    // 3x3 kernel, row-major
    localparam word_t KERNEL [0:WIN_SIZE-1] = '{
        32'sd0, 32'sd1, 32'sd0,
        32'sd1, 32'sd2, 32'sd1,
        32'sd0, 32'sd1, 32'sd0
    };

    // Dense-layer weights, indexed 3*a+b
    localparam word_t FC_WEIGHT [0:POOL_SIZE-1] = '{
        32'sd1, 32'sd2, 32'sd3,
        32'sd4, 32'sd5, 32'sd6,
        32'sd7, 32'sd8, 32'sd9
    };

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONV = 3'd1,
        POOL = 3'd2,
        FC   = 3'd3,
        DONE = 3'd4
    } state_t;

    // Signed maximum of two words
    function automatic word_t max2(input word_t a, input word_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_top_core_conv3x3_window.sv
// Combinational 3x3 convolution of one window followed by ReLU.
module conv3x3_window
    import cnn_pkg::*;
(
    input  word_t pix [0:WIN_SIZE-1],
    output word_t result
);

    word_t sum;

    // Weighted sum wraps at 32 bits; negative results clamp to zero
    always_comb begin
        sum = '0;
        for (int k = 0; k < int'(WIN_SIZE); k++) begin
            sum = sum + KERNEL[k] * pix[k];
        end
        result = sum[WORD_W-1] ? '0 : sum;
    end

endmodule

// File: rtl/cnn_top_core.sv
// Single-image CNN inference: conv3x3 + ReLU, 2x2 max-pool, 9-weight dense.
module cnn_top_core
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_SIZE   = 64,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] input_img [0:IMG_SIZE-1],
    output logic        [OUT_WIDTH-1:0]  value,
    output logic                         done
);

    state_t state, state_nxt;

    word_t       img_buf  [0:IMG_PIXELS-1];
    word_t       conv_buf [0:CONV_SIZE-1];
    word_t       pool_buf [0:POOL_SIZE-1];
    word_t       acc;
    logic [2:0]  row, col;
    logic [3:0]  idx;

    word_t       win_pix [0:WIN_SIZE-1];
    word_t       win_out;
    word_t       pool_max;
    word_t       fc_prod;
    logic [5:0]  conv_idx;
    logic [5:0]  pool_base;
    logic [3:0]  pool_idx;
    logic [3:0]  fc_idx;
    logic        conv_last, pool_last, fc_last;

    conv3x3_window u_window (
        .pix    (win_pix),
        .result (win_out)
    );

    // Window gather, pool/FC addressing and end-of-phase flags
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_pix[i*3+j] = img_buf[6'((int'(row) + i) * int'(IMG_DIM) + int'(col) + j)];
            end
        end
        conv_idx  = 6'(int'(row) * int'(CONV_DIM) + int'(col));
        pool_base = 6'(int'(row) * 2 * int'(CONV_DIM) + int'(col) * 2);
        pool_idx  = 4'(int'(row) * int'(POOL_DIM) + int'(col));
        pool_max  = max2(max2(conv_buf[pool_base], conv_buf[pool_base + 6'd1]),
                         max2(conv_buf[pool_base + 6'(CONV_DIM)],
                              conv_buf[pool_base + 6'(CONV_DIM) + 6'd1]));
        fc_idx    = (idx < 4'(POOL_SIZE)) ? idx : 4'd0;
        fc_prod   = FC_WEIGHT[fc_idx] * pool_buf[fc_idx];
        conv_last = (row == 3'(CONV_DIM - 1)) && (col == 3'(CONV_DIM - 1));
        pool_last = (row == 3'(POOL_DIM - 1)) && (col == 3'(POOL_DIM - 1));
        fc_last   = (idx == 4'(POOL_SIZE));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; enable only matters in IDLE and DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)    state_nxt = CONV;
            CONV:    if (conv_last) state_nxt = POOL;
            POOL:    if (pool_last) state_nxt = FC;
            FC:      if (fc_last)   state_nxt = DONE;
            DONE:    if (!enable)   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath: buffers, counters, accumulator and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(IMG_PIXELS); k++) img_buf[k]  <= '0;
            for (int k = 0; k < int'(CONV_SIZE); k++)  conv_buf[k] <= '0;
            for (int k = 0; k < int'(POOL_SIZE); k++)  pool_buf[k] <= '0;
            acc   <= '0;
            row   <= '0;
            col   <= '0;
            idx   <= '0;
            value <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        for (int k = 0; k < int'(IMG_PIXELS); k++) img_buf[k] <= word_t'(input_img[k]);
                        acc <= '0;
                        row <= '0;
                        col <= '0;
                        idx <= '0;
                    end
                end
                CONV: begin
                    conv_buf[conv_idx] <= win_out;
                    if (col == 3'(CONV_DIM - 1)) begin
                        col <= '0;
                        row <= conv_last ? 3'd0 : row + 3'd1;
                    end else begin
                        col <= col + 3'd1;
                    end
                end
                POOL: begin
                    pool_buf[pool_idx] <= pool_max;
                    if (col == 3'(POOL_DIM - 1)) begin
                        col <= '0;
                        row <= pool_last ? 3'd0 : row + 3'd1;
                    end else begin
                        col <= col + 3'd1;
                    end
                end
                FC: begin
                    // Nine accumulate cycles, then one cycle publishing the result
                    if (fc_last) begin
                        value <= acc[OUT_WIDTH-1:0];
                        done  <= 1'b1;
                        idx   <= '0;
                    end else begin
                        acc <= acc + fc_prod;
                        idx <= idx + 4'd1;
                    end
                end
                DONE: begin
                    if (!enable) done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_top_core.sv
// Directed self-checking bench for cnn_top_core.
module tb_cnn_top_core;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic signed [31:0] img [0:63];
    logic [31:0]        value;
    logic               done;

    int tests  = 0;
    int failed = 0;

    cnn_top_core #(
        .IMG_SIZE   (64),
        .DATA_WIDTH (32),
        .OUT_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .input_img (img),
        .value     (value),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic fill(input logic signed [31:0] v);
        for (int k = 0; k < 64; k++) img[k] = v;
    endtask

    // Start a run; lat is the edge (capture = 0) on which done first rises, -1 on timeout
    task automatic run_to_done(input int drop_at, output int lat, output bit glitch);
        logic [31:0] v0;
        v0 = value;
        lat = -1;
        glitch = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk); #1;
        for (int e = 1; e <= 70; e++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = e;
                break;
            end
            if (value !== v0) glitch = 1'b1;
            if (e == drop_at) enable = 1'b0;
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        fill(32'sd3);
        rst = 1'b1;
        enable = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            tests++;
            if (value !== 32'd0 || done !== 1'b0) begin
                failed++;
                $display("FAIL reset_hold: value=%0d done=%0b required value=0 done=0", value, done);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (value !== 32'd0 || done !== 1'b0) begin
            failed++;
            $display("FAIL reset_release: value=%0d done=%0b required value=0 done=0", value, done);
        end
    endtask

    task automatic test_all_ones();
        int lat;
        bit gl;
        fill(32'sd1);
        run_to_done(0, lat, gl);
        tests++;
        if (lat !== 55) begin
            failed++;
            $display("FAIL ones_latency: got edge %0d required 55", lat);
        end
        tests++;
        if (value !== 32'd270) begin
            failed++;
            $display("FAIL ones_value: got %0d required 270", $signed(value));
        end
        tests++;
        if (gl) begin
            failed++;
            $display("FAIL ones_no_glitch: value changed mid-run, required stable");
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b1 || value !== 32'd270) begin
            failed++;
            $display("FAIL ones_hold: done=%0b value=%0d required done=1 value=270", done, value);
        end
    endtask

    task automatic test_impulse();
        int lat;
        bit gl;
        go_idle();
        fill(32'sd0);
        img[27] = 32'sd5;
        // enable dropped mid-run must not abort the computation
        run_to_done(10, lat, gl);
        tests++;
        if (lat !== 55 || value !== 32'd80) begin
            failed++;
            $display("FAIL impulse: edge=%0d value=%0d required edge=55 value=80", lat, $signed(value));
        end
        tests++;
        if (gl) begin
            failed++;
            $display("FAIL impulse_no_glitch: value changed mid-run, required stable");
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || value !== 32'd80) begin
            failed++;
            $display("FAIL impulse_after_drop: done=%0b value=%0d required done=0 value=80", done, value);
        end
    endtask

    task automatic test_negative();
        int lat;
        bit gl;
        go_idle();
        fill(-32'sd1);
        run_to_done(0, lat, gl);
        tests++;
        if (lat !== 55 || value !== 32'd0) begin
            failed++;
            $display("FAIL negative_relu: edge=%0d value=%0d required edge=55 value=0", lat, $signed(value));
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        bit gl;
        go_idle();
        fill(32'sd1);
        run_to_done(0, lat, gl);
        go_idle();
        fill(32'sd2);
        @(negedge clk);
        enable = 1'b1;
        repeat (21) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (done !== 1'b0 || value !== 32'd0) begin
            failed++;
            $display("FAIL midrun_reset: done=%0b value=%0d required done=0 value=0", done, value);
        end
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        fill(32'sd1);
        run_to_done(0, lat, gl);
        tests++;
        if (lat !== 55 || value !== 32'd270) begin
            failed++;
            $display("FAIL rerun_after_reset: edge=%0d value=%0d required edge=55 value=270", lat, $signed(value));
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit gl;
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || value !== 32'd270) begin
            failed++;
            $display("FAIL drop_enable: done=%0b value=%0d required done=0 value=270", done, value);
        end
        fill(32'sd0);
        run_to_done(0, lat, gl);
        tests++;
        if (lat !== 55 || value !== 32'd0) begin
            failed++;
            $display("FAIL zeros_rerun: edge=%0d value=%0d required edge=55 value=0", lat, $signed(value));
        end
        tests++;
        if (gl) begin
            failed++;
            $display("FAIL zeros_no_glitch: value changed mid-run, required stable at 270");
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        fill(32'sd0);
        test_reset();
        test_all_ones();
        test_impulse();
        test_negative();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
